// File: rtl/debug_hex_display.sv
// debug_hex_display: selects one of N_CH debug words (manual step or auto-rotate) and drives the
// seven-segment bank in hex or in decimal (sequential double-dabble), with leading-zero blanking and overflow dashes.
module debug_hex_display #(
   parameter int N_CH          = 4,
   parameter int DATA_W        = 32,
   parameter int N_DIGITS      = 8,
   parameter int ROTATE_CYCLES = 50_000_000
) (
   input  logic                                 i_clk,
   input  logic                                 i_rst_n,
   input  logic [N_CH*DATA_W-1:0]               i_data,
   input  logic                                 i_next,
   input  logic                                 i_auto,
   input  logic                                 i_mode_dec,
   input  logic                                 i_blank_lz,
   input  logic                                 i_freeze,
   output logic [N_DIGITS*7-1:0]                o_seven,
   output logic [(N_CH > 1 ? $clog2(N_CH) : 1)-1:0] o_ch,
   output logic                                 o_busy
);
   localparam int CH_W  = N_CH > 1 ? $clog2(N_CH) : 1;
   localparam int BCD_W = 4 * N_DIGITS;
   localparam int EXT_W = DATA_W > BCD_W ? DATA_W : BCD_W;
   localparam int CNT_W = $clog2(ROTATE_CYCLES);
   localparam int IT_W  = $clog2(DATA_W);
   localparam logic [6:0] DASH  = 7'b0111111;
   localparam logic [6:0] BLANK = 7'b1111111;
   localparam logic [6:0] GLYPH [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   typedef enum logic [1:0] {IDLE, LOAD, CONV, SHOW} state_t;
   state_t r_state, w_state_nx;

   logic [CH_W-1:0]      r_sel, r_ch_l;
   logic [CNT_W-1:0]     r_rot;
   logic                 r_next_q;
   logic [DATA_W-1:0]    r_snap;
   logic [BCD_W-1:0]     r_bcd, w_adj, w_val;
   logic                 r_dec, r_blank, r_ovf;
   logic [IT_W-1:0]      r_iter;
   logic                 w_tick, w_adv, w_last, w_ovf;
   logic [EXT_W-1:0]     w_ext;
   logic [N_DIGITS*7-1:0] w_seven;

   // a coincident tick and i_next edge still advance by one
   assign w_tick = i_auto && r_rot == CNT_W'(ROTATE_CYCLES - 1);
   assign w_adv  = w_tick || (i_next && !r_next_q);
   assign w_last = r_iter == IT_W'(DATA_W - 1);
   assign o_busy = r_state != IDLE;

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_sel    <= '0;
         r_rot    <= '0;
         r_next_q <= 1'b0;
      end else begin
         r_next_q <= i_next;
         r_rot    <= (!i_auto || w_tick) ? '0 : r_rot + 1'b1;
         if (w_adv) r_sel <= r_sel == CH_W'(N_CH - 1) ? '0 : r_sel + 1'b1;
      end

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_state_nx;

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         IDLE:    w_state_nx = i_freeze ? IDLE : LOAD;
         LOAD:    w_state_nx = i_mode_dec ? CONV : SHOW;
         CONV:    w_state_nx = w_last ? SHOW : CONV;
         SHOW:    w_state_nx = IDLE;
         default: w_state_nx = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_snap  <= '0;
         r_bcd   <= '0;
         r_dec   <= 1'b0;
         r_blank <= 1'b0;
         r_ovf   <= 1'b0;
         r_iter  <= '0;
         r_ch_l  <= '0;
         o_seven <= '1;
         o_ch    <= '0;
      end else begin
         if (r_state == LOAD) begin
            r_snap  <= i_data[DATA_W*int'(r_sel) +: DATA_W];
            r_dec   <= i_mode_dec;
            r_blank <= i_blank_lz;
            r_ch_l  <= r_sel;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
            r_iter  <= '0;
         end
         if (r_state == CONV) begin
            r_bcd  <= {w_adj[BCD_W-2:0], r_snap[DATA_W-1]};
            r_snap <= r_snap << 1;
            r_ovf  <= r_ovf | w_adj[BCD_W-1];
            r_iter <= r_iter + 1'b1;
         end
         if (r_state == SHOW) begin
            o_seven <= w_seven;
            o_ch    <= r_ch_l;
         end
      end

   always_comb begin
      w_adj = r_bcd;
      for (int k = 0; k < N_DIGITS; k++)
         w_adj[k*4 +: 4] = r_bcd[k*4 +: 4] > 4'd4 ? r_bcd[k*4 +: 4] + 4'd3 : r_bcd[k*4 +: 4];
   end

   // hex shows the zero-extended snapshot directly; anything above the digit bank is overflow
   assign w_ext = EXT_W'(r_snap);
   assign w_val = r_dec ? r_bcd : w_ext[BCD_W-1:0];
   assign w_ovf = r_dec ? r_ovf : |(w_ext >> BCD_W);

   always_comb begin : render
      logic seen;
      seen    = 1'b0;
      w_seven = '1;
      for (int k = N_DIGITS - 1; k >= 0; k--) begin
         seen = seen || w_val[k*4 +: 4] != 4'd0;
         w_seven[k*7 +: 7] = w_ovf ? DASH : (r_blank && k != 0 && !seen) ? BLANK : GLYPH[w_val[k*4 +: 4]];
      end
   end
endmodule

// File: tb/tb_debug_hex_display.sv
// tb_debug_hex_display: directed scoreboard bench for debug_hex_display (8-digit main instance, 4-digit overflow instance).
module tb_debug_hex_display;
   localparam int N_CH = 4, DATA_W = 32, ND = 8, RC = 10;
   localparam logic [6:0] DASH = 7'b0111111;
   localparam logic [6:0] BLK  = 7'b1111111;
   localparam logic [6:0] GLYPH [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   logic clk = 1'b0, rst_n = 1'b0;
   logic [N_CH*DATA_W-1:0] data = '0;
   logic nxt = 1'b0, auto_en = 1'b0, dec = 1'b0, blank = 1'b0, frz = 1'b0;
   logic [ND*7-1:0] seven;
   logic [27:0] seven4;
   logic [1:0] ch, ch4;
   logic busy, busy4;
   int errors = 0, checks = 0;
   logic [63:0] sb [$];

   always #5 clk = ~clk;

   debug_hex_display #(.N_CH(N_CH), .DATA_W(DATA_W), .N_DIGITS(ND), .ROTATE_CYCLES(RC)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_next(nxt), .i_auto(auto_en),
      .i_mode_dec(dec), .i_blank_lz(blank), .i_freeze(frz),
      .o_seven(seven), .o_ch(ch), .o_busy(busy));

   debug_hex_display #(.N_CH(N_CH), .DATA_W(DATA_W), .N_DIGITS(4), .ROTATE_CYCLES(RC)) u_dut4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_next(nxt), .i_auto(auto_en),
      .i_mode_dec(dec), .i_blank_lz(blank), .i_freeze(frz),
      .o_seven(seven4), .o_ch(ch4), .o_busy(busy4));

   function automatic logic [55:0] mdl(longint unsigned v, bit d, bit b);
      longint unsigned base, p;
      base = d ? 64'd10 : 64'd16;
      p = 1;
      for (int k = 0; k < 8; k++) p *= base;
      if (v >= p) return {8{DASH}};
      mdl = '1;
      p = 1;
      for (int k = 0; k < 8; k++) begin
         mdl[k*7 +: 7] = (b && k > 0 && v < p) ? BLK : GLYPH[4'((v / p) % base)];
         p *= base;
      end
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(longint unsigned v, int c);
      sb.push_back({8'(c), mdl(v, dec, blank)});
   endtask

   task automatic pop_chk(string tag);
      logic [63:0] e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: observed empty scoreboard expected an entry", tag);
         return;
      end
      e = sb.pop_front();
      chk({tag, ".seven"}, 64'(seven), 64'(e[55:0]));
      chk({tag, ".ch"}, 64'(ch), 64'(e[63:56]));
   endtask

   task automatic wait_done(int n, string tag);
      int seen = 0;
      logic prev = busy;
      for (int i = 0; i < 3000 && seen < n; i++) begin
         @(negedge clk);
         if (prev && !busy) seen++;
         prev = busy;
      end
      if (seen < n) begin
         checks++;
         errors++;
         $error("FAIL %s: observed %0d refreshes expected %0d (timeout)", tag, seen, n);
      end
   endtask

   task automatic wait_busy(logic lvl, string tag);
      int i = 0;
      while (busy !== lvl && i < 3000) begin
         @(negedge clk);
         i++;
      end
      if (busy !== lvl) begin
         checks++;
         errors++;
         $error("FAIL %s: observed busy %b expected %b (timeout)", tag, busy, lvl);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [1:0] prev_ch;
      int i;
      // reset state and first hex display timing
      data[31:0] = 32'hDEADBEEF;
      blank = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst.seven", 64'(seven), 64'({56{1'b1}}));
      chk("rst.ch", 64'(ch), 64'd0);
      chk("rst.busy", 64'(busy), 64'd0);
      chk("rst.seven4", 64'(seven4), 64'({28{1'b1}}));
      push(32'hDEADBEEF, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("busy_clk1", 64'(busy), 64'd1);
      @(negedge clk);
      chk("busy_clk2", 64'(busy), 64'd1);
      chk("hex_not_early", 64'(seven), 64'({56{1'b1}}));
      @(negedge clk);
      pop_chk("hex_deadbeef");
      data[31:0] = 32'h0000_00A5;
      push(32'hA5, 0);
      wait_done(2, "hex_a5_wait");
      pop_chk("hex_a5");
      // 4-digit instance overflows above 16 bits
      data[31:0] = 32'h0001_0000;
      push(32'h1_0000, 0);
      wait_done(2, "hex_ovf_wait");
      pop_chk("hex_10000");
      chk("hex4_ovf", 64'(seven4), 64'({4{DASH}}));
      data[31:0] = 32'h0000_FFFF;
      push(32'hFFFF, 0);
      wait_done(2, "hex_ffff_wait");
      pop_chk("hex_ffff");
      chk("hex4_ffff", 64'(seven4), 64'({4{GLYPH[15]}}));
      // decimal, exact latency from LOAD
      dec = 1'b1;
      data[31:0] = 32'd12345678;
      push(12345678, 0);
      wait_busy(1'b0, "dec_idle");
      @(negedge clk);
      wait_busy(1'b1, "dec_load");
      repeat (DATA_W + 1) @(negedge clk);
      chk("dec_not_early", 64'(seven), 64'(mdl(32'hFFFF, 1'b0, 1'b1)));
      @(negedge clk);
      pop_chk("dec_12345678");
      data[31:0] = 32'd0;
      push(0, 0);
      wait_done(2, "dec_zero_wait");
      pop_chk("dec_zero_blank");
      blank = 1'b0;
      push(0, 0);
      wait_done(2, "dec_zero_nb_wait");
      pop_chk("dec_zero_noblank");
      blank = 1'b1;
      data[31:0] = 32'd10203;
      push(10203, 0);
      wait_done(2, "dec_10203_wait");
      pop_chk("dec_10203");
      data[31:0] = 32'd99999999;
      push(99999999, 0);
      wait_done(2, "dec_max_wait");
      pop_chk("dec_99999999");
      data[31:0] = 32'd100000000;
      push(100000000, 0);
      wait_done(2, "dec_ovf_wait");
      pop_chk("dec_100000000");
      // auto rotation
      dec = 1'b0;
      for (int c = 0; c < N_CH; c++) data[c*32 +: 32] = 32'h10 + 32'(c);
      push(32'h10, 0);
      wait_done(2, "auto_pre_wait");
      pop_chk("auto_start");
      push(32'h11, 1);
      push(32'h12, 2);
      push(32'h13, 3);
      push(32'h10, 0);
      auto_en = 1'b1;
      prev_ch = ch;
      i = 0;
      while (sb.size() != 0 && i < 400) begin
         @(negedge clk);
         if (ch !== prev_ch) begin
            pop_chk("auto_rot");
            prev_ch = ch;
         end
         i++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $error("FAIL auto_rot: observed %0d pending expected 0 (timeout)", sb.size());
         sb.delete();
      end
      auto_en = 1'b0;
      // i_next edge coincident with the rotate tick
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      auto_en = 1'b1;
      repeat (9) @(negedge clk);
      nxt = 1'b1;
      @(negedge clk);
      auto_en = 1'b0;
      push(32'h11, 1);
      wait_done(2, "coinc_wait");
      pop_chk("coincident");
      for (int c = 2; c <= 4; c++) begin
         nxt = 1'b0;
         @(negedge clk);
         nxt = 1'b1;
         push(32'h10 + 32'(c % 4), c % 4);
         wait_done(2, "next_wait");
         pop_chk("next_step");
      end
      nxt = 1'b0;
      // freeze holds the display while sel still advances
      data[31:0] = 32'h1234ABCD;
      push(32'h1234ABCD, 0);
      wait_done(2, "frz_pre_wait");
      pop_chk("pre_freeze");
      frz = 1'b1;
      wait_busy(1'b0, "frz_idle");
      for (int k = 0; k < 100; k++) begin
         data[31:0] = $urandom;
         nxt = (k == 50);
         @(negedge clk);
         if (k % 10 == 9) begin
            chk("frz.seven", 64'(seven), 64'(mdl(32'h1234ABCD, 1'b0, 1'b1)));
            chk("frz.ch", 64'(ch), 64'd0);
            chk("frz.busy", 64'(busy), 64'd0);
         end
      end
      nxt = 1'b0;
      frz = 1'b0;
      push(32'h11, 1);
      wait_done(2, "unfrz_wait");
      pop_chk("post_freeze");
      // asynchronous reset in the middle of a decimal conversion
      dec = 1'b1;
      data[31:0] = 32'd87654321;
      wait_busy(1'b0, "mid_idle");
      @(negedge clk);
      wait_busy(1'b1, "mid_load");
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst.seven", 64'(seven), 64'({56{1'b1}}));
      chk("mid_rst.ch", 64'(ch), 64'd0);
      chk("mid_rst.busy", 64'(busy), 64'd0);
      data[31:0] = 32'd11223344;
      push(11223344, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (DATA_W + 2) @(negedge clk);
      chk("mid_not_early", 64'(seven), 64'({56{1'b1}}));
      @(negedge clk);
      pop_chk("mid_fresh");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/debug_hex_display.md
# debug_hex_display

Parametrised multi-channel debug display driver for the board's seven-segment bank. It takes N_CH packed debug words from the SoC (e.g. the RSA core's debug counters) and selects one channel, manually or by auto-rotation. The selected word is rendered as hex or as unsigned decimal, with a sequential double-dabble converter, optional leading-zero blanking and overflow indication. It sits in the board top level between the Qsys system and the HEX pins.

## Interface
- N_CH, 4: number of debug channels (≥1)
- DATA_W, 32: width of each channel word (≥4)
- N_DIGITS, 8: number of seven-segment digits driven (≥1)
- ROTATE_CYCLES, 50_000_000: auto-rotate dwell in clock cycles (≥2)

- i_clk  in  1  single system clock; all logic on its rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_data  in  N_CH*DATA_W  channel c = i_data[c*DATA_W +: DATA_W]
- i_next  in  1  advance channel; level input, rising edge detected internally
- i_auto  in  1  1 = auto-rotate channels every ROTATE_CYCLES
- i_mode_dec  in  1  0 = hex, 1 = unsigned decimal
- i_blank_lz  in  1  1 = blank leading zeros
- i_freeze  in  1  1 = hold display, start no new conversion
- o_seven  out  N_DIGITS*7  digit k = o_seven[k*7 +: 7], k=0 rightmost; active-low, bit0=a … bit6=g
- o_ch  out  max(1,$clog2(N_CH))  channel of the value currently displayed
- o_busy  out  1  conversion in progress

## Operation
- Glyphs: 0–F use standard DE2 active-low codes (0 = 7'b1000000, 8 = 7'b0000000). Blank = 7'b1111111. Dash = 7'b0111111.
- Channel select `sel`:
  - `sel` advances by 1 on an i_next rising edge, or on an auto tick when i_auto=1.
  - Wraps N_CH-1 → 0.
  - Edge and tick in the same cycle advance by 1 only.
  - Rotate counter counts 0..ROTATE_CYCLES-1, ticks at wrap, and is held at 0 while i_auto=0.
- FSM IDLE → LOAD → CONV → SHOW → IDLE:
  - IDLE: go to LOAD when i_freeze=0, otherwise stay.
  - LOAD: snap ← channel `sel`; latch mode, blank flag and `sel`.
  - CONV: skipped in hex mode. In decimal mode run DATA_W double-dabble iterations, one per cycle, on a 4*N_DIGITS-bit BCD register.
  - SHOW: write o_seven and o_ch from the latched values.
- Changes to mode, blank or `sel` mid-conversion take effect at the next LOAD.
- Overflow:
  - hex: overflow if snap bits above 4*N_DIGITS-1 are non-zero.
  - decimal: overflow if any 1 is shifted out of the top BCD digit.
  - On overflow every digit shows dash.
- Narrow data: DATA_W < 4*N_DIGITS is zero-extended.
- Leading-zero blanking: digits above the most significant non-zero digit are blank. A value of 0 shows "0" on digit 0 with the rest blank. Blanking never applies during overflow.
- i_freeze=1: the current conversion completes and displays; after that the FSM holds in IDLE and `sel` keeps advancing.
- Reset mid-operation: everything returns to reset values immediately (asynchronous). The partial conversion is discarded.

## Timing
- Reset values:
  - o_seven all 7'b1111111, o_ch 0, o_busy 0
  - FSM IDLE, sel 0, rotate counter 0, edge register 0
- i_data is sampled in the LOAD cycle only.
- o_busy = 1 in LOAD, CONV and SHOW.
- Hex refresh: LOAD at cycle t, SHOW at t+1, o_seven valid at t+2. Period 3 cycles.
- Decimal refresh: LOAD at t, CONV t+1..t+DATA_W, SHOW at t+DATA_W+1, valid at t+DATA_W+2. Period DATA_W+3 cycles.
- i_next edge: `sel` changes the cycle after the edge. The display shows the new channel at most one full conversion plus one refresh later.
- First display after reset release: valid at cycle 3 (hex) or DATA_W+3 (decimal) counting from the first clock with i_rst_n=1.

## Test plan
- Reset: hold i_rst_n=0 → o_seven all 7'b1111111, o_ch=0, o_busy=0. Release → o_busy=1 on the 2nd clock.
- Hex: ch0=32'hDEADBEEF, i_mode_dec=0, i_blank_lz=1 → digits 7..0 show D,E,A,D,B,E,E,F. Then ch0=32'h0000_00A5 → digits 1,0 show A,5, digits 7..2 blank.
- Decimal: ch0=12345678, i_mode_dec=1 → "12345678" valid exactly DATA_W+2 cycles after LOAD. ch0=0 with i_blank_lz=1 → digit 0 = 7'b1000000, others blank.
- Overflow: decimal with ch0=100000000 → all 8 digits dash. Hex with N_DIGITS=4, ch0=32'h0001_0000 → all dashes.
- Channel selection, N_CH=4, ROTATE_CYCLES=10:
  - i_auto=1 → o_ch cycles 0,1,2,3,0.
  - i_next edge coincident with a tick → sel advances by exactly 1.
  - i_freeze=1 → o_seven and o_ch constant for 100 cycles while ch0 changes.
- Reset mid-CONV: assert i_rst_n=0 at CONV iteration 10 → outputs return to reset values asynchronously. After release the first displayed value is the fresh conversion.
